// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream bundle for alu_cmd_ctrl: UART RX in, UART TX out, status.
// Both byte streams are valid/ready; a byte moves when valid & ready.
interface alu_cmd_ctrl_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    // Controller side
    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
    );

    // Byte source/sink side (UART wrapper or bench)
    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses [op][rsvd][len_lo][len_hi][payload] packets from the RX
// byte stream, runs ECHO/ADD/XOR (and MUL) and streams the response to TX.
// Optional feature macro: ALU_CMD_MUL_EN builds the multiplier and makes 0x88 legal.
module alu_cmd_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_cmd_ctrl_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int OW = (NB > 1) ? DATA_W - 8 : 1;
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [15:0] NB16      = 16'(NB);
    localparam logic [CW-1:0] LAST_B  = CW'(NB - 1);
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_XOR  = 8'hA5;
`ifdef ALU_CMD_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h88;
`endif

    typedef enum logic [2:0] {
        S_OP, S_RSVD, S_LLO, S_LHI, S_ECHO, S_OPND, S_RES, S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        opcode_q, len_lo_q, tx_data_q;
    logic [15:0]       rem_q;
    logic [CW-1:0]     bidx_q, res_left_q;
    logic [OW-1:0]     opnd_q;
    logic [DATA_W-1:0] acc_q;
    logic              tx_valid_q, err_q;

    logic              rx_ready, rx_fire, tx_fire;
    logic [15:0]       len_w, rem_w;
    logic              op_alu, op_known, len_short, len_long, hdr_bad;
    logic [DATA_W-1:0] operand_w, ident_w, acc_nxt, acc_sh;

    assign rx_fire = bus.rx_valid_i & rx_ready;
    assign tx_fire = tx_valid_q & bus.tx_ready_i;
    assign acc_sh  = acc_q >> 8;

    // Operand assembled little-endian: earlier bytes sit in opnd_q, newest byte on top
    if (NB > 1) begin : g_opnd
        assign operand_w = {bus.rx_data_i, opnd_q};
    end else begin : g_opnd1
        assign operand_w = bus.rx_data_i;
    end

    // Header decode, evaluated against the length high byte on the bus
    always_comb begin
        len_w     = {bus.rx_data_i, len_lo_q};
        rem_w     = len_w - 16'd4;
        op_alu    = (opcode_q == OP_ADD) || (opcode_q == OP_XOR);
        ident_w   = '0;
`ifdef ALU_CMD_MUL_EN
        if (opcode_q == OP_MUL) begin
            op_alu  = 1'b1;
            ident_w = DATA_W'(1);
        end
`endif
        op_known  = op_alu || (opcode_q == OP_ECHO);
        len_short = len_w < 16'd4;
        len_long  = len_w > MAX_LEN16;
        hdr_bad   = len_short || len_long || !op_known ||
                    (op_alu && ((rem_w % NB16) != 16'd0));
    end

    // Accumulator value after this cycle: identity at header end, op on last operand byte
    always_comb begin
        acc_nxt = acc_q;
        if (state == S_LHI) begin
            acc_nxt = ident_w;
        end else if (state == S_OPND && rx_fire && bidx_q == LAST_B) begin
            case (opcode_q)
                OP_ADD:  acc_nxt = acc_q + operand_w;
                OP_XOR:  acc_nxt = acc_q ^ operand_w;
`ifdef ALU_CMD_MUL_EN
                OP_MUL:  acc_nxt = acc_q * operand_w;
`endif
                default: acc_nxt = acc_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_OP;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_OP:   if (rx_fire) state_nxt = S_RSVD;
            S_RSVD: if (rx_fire) state_nxt = S_LLO;
            S_LLO:  if (rx_fire) state_nxt = S_LHI;
            S_LHI: if (rx_fire) begin
                if (len_short)                 state_nxt = S_OP;
                else if (hdr_bad)              state_nxt = (rem_w == 16'd0) ? S_OP : S_DRAIN;
                else if (opcode_q == OP_ECHO)  state_nxt = (rem_w == 16'd0) ? S_OP : S_ECHO;
                else                           state_nxt = (rem_w == 16'd0) ? S_RES : S_OPND;
            end
            S_ECHO, S_DRAIN: if (rx_fire && rem_q == 16'd1) state_nxt = S_OP;
            S_OPND:          if (rx_fire && rem_q == 16'd1) state_nxt = S_RES;
            S_RES:           if (tx_fire && res_left_q == '0) state_nxt = S_OP;
            default:         state_nxt = S_OP;
        endcase
    end

    // Outputs: RX back-pressure per state, busy outside S_OP
    always_comb begin
        rx_ready = 1'b1;
        case (state)
            // A buffered echo byte must leave before (or as) the next byte enters
            S_OP, S_ECHO: rx_ready = !tx_valid_q || bus.tx_ready_i;
            S_RES:        rx_ready = 1'b0;
            default:      rx_ready = 1'b1;
        endcase
    end

    assign bus.rx_ready_o = rx_ready;
    assign bus.busy_o     = (state != S_OP);
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.err_o      = err_q;

    // Datapath: header capture, payload counting, operand/accumulator, TX holding register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            bidx_q     <= '0;
            res_left_q <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (tx_fire) tx_valid_q <= 1'b0;
            case (state)
                S_OP:  if (rx_fire) opcode_q <= bus.rx_data_i;
                S_LLO: if (rx_fire) len_lo_q <= bus.rx_data_i;
                S_LHI: if (rx_fire) begin
                    rem_q  <= rem_w;
                    bidx_q <= '0;
                    acc_q  <= acc_nxt;
                    err_q  <= hdr_bad;
                end
                S_ECHO: if (rx_fire) begin
                    rem_q      <= rem_q - 16'd1;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= bus.rx_data_i;
                end
                S_OPND: if (rx_fire) begin
                    rem_q  <= rem_q - 16'd1;
                    opnd_q <= operand_w[DATA_W-1 -: OW];
                    bidx_q <= (bidx_q == LAST_B) ? '0 : bidx_q + CW'(1);
                    acc_q  <= acc_nxt;
                end
                S_DRAIN: if (rx_fire) rem_q <= rem_q - 16'd1;
                // acc doubles as the result shift register, LSB byte out first
                S_RES: if (tx_fire && res_left_q != '0) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= acc_sh[7:0];
                    acc_q      <= acc_sh;
                    res_left_q <= res_left_q - CW'(1);
                end
                default: ;
            endcase
            if (state != S_RES && state_nxt == S_RES) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= acc_nxt[7:0];
                res_left_q <= LAST_B;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a TX byte scoreboard.
module tb_alu_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_ctrl_if bus();
    alu_cmd_ctrl #(.DATA_W(32), .MAX_LEN(1024)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];
    logic tgl_en = 1'b0;

    // TX ready: held high, or toggled every cycle when tgl_en is set
    initial begin
        bus.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready_i = tgl_en ? ~bus.tx_ready_i : 1'b1;
        end
    end

    // TX monitor: scoreboard pop, stall stability, err pulse counting
    initial begin : mon
        logic       stall;
        logic [7:0] held;
        logic [7:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (bus.err_o) err_cnt++;
                if (stall) begin
                    n_cmp++;
                    assert (bus.tx_valid_o === 1'b1 && bus.tx_data_o === held) else begin
                        n_fail++;
                        $error("FAIL tx_stable: got v=%b d=%h, need v=1 d=%h", bus.tx_valid_o, bus.tx_data_o, held);
                    end
                end
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        assert (0) else begin
                            n_fail++;
                            $error("FAIL tx_unexpected: got %h, need no tx", bus.tx_data_o);
                        end
                    end else begin
                        e = exp_q.pop_front();
                        assert (bus.tx_data_o === e) else begin
                            n_fail++;
                            $error("FAIL tx_byte: got %h, need %h", bus.tx_data_o, e);
                        end
                    end
                end
                stall = bus.tx_valid_o && !bus.tx_ready_i;
                held  = bus.tx_data_o;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] need);
        n_cmp++;
        assert (got === need) else begin
            n_fail++;
            $error("FAIL %s: got %h, need %h", tag, got, need);
        end
    endtask

    // Send one byte; called just after a negedge, returns just after a negedge
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        while (!bus.rx_ready_o) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_fail++;
                $display("FAIL rx_timeout: got rx_ready_o=0 for 200 cycles, need 1");
                $fatal(1, "rx stuck");
            end
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input int max_gap);
        while (pkt.size() != 0) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send(pkt.pop_front());
        end
    endtask

    task automatic hdr(input logic [7:0] op, input logic [15:0] len);
        pkt.push_back(op); pkt.push_back(8'h00);
        pkt.push_back(len[7:0]); pkt.push_back(len[15:8]);
    endtask

    task automatic word(input logic [31:0] w, input bit to_pkt);
        for (int i = 0; i < 4; i++) begin
            if (to_pkt) pkt.push_back(w[8*i +: 8]);
            else        exp_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        int e0;
        logic [7:0] b;
        bus.rx_data_i  = '0;
        bus.rx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
        chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data_o),  32'd0);
        chk("rst_busy",     32'(bus.busy_o),     32'd0);
        chk("rst_err",      32'(bus.err_o),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ECHO 3 bytes
        hdr(8'hEC, 16'd7);
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        send_pkt(0);
        chk("echo_busy_low", 32'(bus.busy_o), 32'd0);
        drain("echo_drain");

        // ADD with wrap
        e0 = err_cnt;
        hdr(8'hAD, 16'd12); word(32'hFFFF_FFFF, 1); word(32'h2, 1);
        word(32'h1, 0);
        send_pkt(0);
        drain("add_drain");
        chk("add_no_err", 32'(err_cnt - e0), 32'd0);

        // XOR empty payload: identity
        hdr(8'hA5, 16'd4); word(32'h0, 0);
        send_pkt(0);
        drain("xor_ident");

        // ADD misaligned payload
        e0 = err_cnt;
        hdr(8'hAD, 16'd7);
        pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
        send_pkt(0);
        drain("misalign_no_tx");
        chk("misalign_err", 32'(err_cnt - e0), 32'd1);
        chk("misalign_busy", 32'(bus.busy_o), 32'd0);

        // MUL: legal only with the multiplier built
        e0 = err_cnt;
        hdr(8'h88, 16'd12); word(32'h3, 1); word(32'h5, 1);
`ifdef ALU_CMD_MUL_EN
        word(32'h0F, 0);
`endif
        send_pkt(0);
        drain("mul_drain");
`ifdef ALU_CMD_MUL_EN
        chk("mul_err", 32'(err_cnt - e0), 32'd0);
`else
        chk("mul_err", 32'(err_cnt - e0), 32'd1);
`endif
        hdr(8'hEC, 16'd5); pkt.push_back(8'hAB); exp_q.push_back(8'hAB);
        send_pkt(0);
        drain("after_mul_echo");

        // Length too short: err, straight back to header parsing
        e0 = err_cnt;
        hdr(8'hEC, 16'd2);
        send_pkt(0);
        repeat (2) @(negedge clk);
        chk("short_err", 32'(err_cnt - e0), 32'd1);
        chk("short_busy", 32'(bus.busy_o), 32'd0);

        // Length above MAX_LEN: err, payload drained
        e0 = err_cnt;
        hdr(8'hEC, 16'd1025);
        for (int i = 0; i < 1021; i++) pkt.push_back(8'(i));
        send_pkt(0);
        drain("long_no_tx");
        chk("long_err", 32'(err_cnt - e0), 32'd1);
        chk("long_busy", 32'(bus.busy_o), 32'd0);

        // Unknown opcode
        e0 = err_cnt;
        hdr(8'h55, 16'd5); pkt.push_back(8'h99);
        send_pkt(0);
        drain("unk_no_tx");
        chk("unk_err", 32'(err_cnt - e0), 32'd1);

        // ECHO under TX stalls and RX gaps
        tgl_en = 1'b1;
        hdr(8'hEC, 16'd16);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            pkt.push_back(b);
            exp_q.push_back(b);
        end
        send_pkt(2);
        drain("echo_stall");
        tgl_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an operand
        hdr(8'hAD, 16'd12); pkt.push_back(8'h01); pkt.push_back(8'h02);
        send_pkt(0);
        chk("mid_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        hdr(8'hAD, 16'd12); word(32'd5, 1); word(32'd7, 1);
        word(32'h0C, 0);
        send_pkt(0);
        drain("post_rst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
